eth_axis_rx_parse: RTL and testbench
====================================

ETH_AXIS_RX_PARSE -- requirements
Module: eth_axis_rx_parse

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, stream width in bits; 8 is the only supported value.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  raw frame stream, header bytes first.
REQ-005 SHALL have ports m_eth_hdr_valid/m_eth_hdr_ready  out/in  1/1  header handshake.
REQ-006 SHALL have ports m_eth_dest_mac/m_eth_src_mac/m_eth_type  out  48/48/16  parsed header fields.
REQ-007 SHALL have ports m_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  payload stream.
REQ-008 SHALL have ports busy, error_header_early_termination  out  1 each  status.

Function
REQ-009 SHALL implement states IDLE, READ_HEADER, READ_PAYLOAD; 4-bit header byte counter 0..13.
REQ-010 SHALL set s_axis_tready in IDLE/READ_HEADER = NOT m_eth_hdr_valid; a new header is not accepted while the previous one is unconsumed.
REQ-011 SHALL, on each accepted header byte, store it by index: 0-5 dest_mac [47:40] first, 6-11 src_mac MSB first, 12-13 eth_type MSB first; counter increments.
REQ-012 SHALL transition IDLE->READ_HEADER on the first accepted byte (index 0, tlast=0).
REQ-013 SHALL, when byte 13 is accepted with tlast=0, assert m_eth_hdr_valid the next cycle, with field outputs stable, and enter READ_PAYLOAD.
REQ-014 SHALL hold m_eth_hdr_valid and fields until the cycle m_eth_hdr_ready=1, then deassert next cycle.
REQ-015 SHALL, when tlast=1 on any header byte 0..13, discard the frame, not assert m_eth_hdr_valid, pulse error_header_early_termination for exactly one cycle, and return to IDLE.
REQ-016 SHALL in READ_PAYLOAD pass bytes through a registered output stage plus one-entry skid buffer; s_axis_tready is registered and depends only on buffer occupancy.
REQ-017 SHALL deliver each accepted payload byte on the output no earlier than the cycle after acceptance, in order, with no loss or duplication under any tready pattern.
REQ-018 SHALL forward tlast and tuser with their byte; the tlast byte returns the FSM to IDLE.
REQ-019 SHALL let payload flow regardless of m_eth_hdr_ready; only the next frame's header is blocked.
REQ-020 SHALL drive busy=1 whenever state is not IDLE.
REQ-021 SHALL support back-to-back frames: byte 0 of frame N+1 is accepted the cycle after frame N's tlast byte, provided m_eth_hdr_valid=0.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, counter 0, skid empty, and all outputs 0 (s_axis_tready, m_eth_hdr_valid, payload tvalid/tlast/tuser, busy, error, field registers).
REQ-023 SHALL, after rst deasserts mid-frame, treat the next accepted byte as header byte 0; no partial header or payload is emitted.
REQ-024 SHALL raise s_axis_tready on the first clock edge after rst deasserts.

Verification
REQ-025 Bench SHALL send 14-byte header dest 02:00:00:00:00:01, src 5A:51:52:53:54:55, type 0x8000, then 10 payload bytes 0x00..0x09, with all readies held high -> header valid once with those fields; payload 0x00..0x09, tlast only on 0x09.
REQ-026 Bench SHALL send a 10-byte frame with tlast on byte 9 -> error pulse exactly 1 cycle; no hdr_valid; no payload; busy returns 0.
REQ-027 Bench SHALL run two back-to-back frames, holding m_eth_hdr_ready=0 for 20 cycles -> frame 1 payload completes; s_axis_tready=0 on frame 2 byte 0 until header 1 is consumed; frame 2 is then parsed correctly.
REQ-028 Bench SHALL toggle m_eth_payload_axis_tready pseudo-randomly (50%) over a 64-byte payload with tuser=1 on the last byte -> byte-exact output; tuser=1 only with tlast.
REQ-029 Bench SHALL assert rst=0 for 2 cycles after header byte 7, then send a full frame -> all outputs 0 during reset; full frame parsed correctly afterwards.
REQ-030 Bench SHALL send a 14-byte frame with tlast on byte 13 -> error pulse; no header output.

Source files
------------

// File: rtl/eth_axis_rx_parse.sv
`default_nettype none
// ============================================================================
//  Module      : eth_axis_rx_parse
//  Description : Splits a raw byte-wide Ethernet frame stream into a 14-byte
//                header (dest MAC, src MAC, EtherType) handed over with a
//                valid/ready handshake, and a payload AXI-Stream that passes
//                through a registered output stage backed by a one-entry
//                skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_axis_rx_parse #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,

  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,

  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,

  output logic                  busy,
  output logic                  error_header_early_termination
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_READ_HEADER  = 2'd1,
    ST_READ_PAYLOAD = 2'd2
  } state_t;

  // Index of the final header byte (EtherType LSB).
  localparam logic [3:0] c_HDR_LAST_IDX = 4'd13;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_hdr_cnt;
  logic                  r_s_ready;
  logic                  r_hdr_valid;
  logic [47:0]           r_dest_mac;
  logic [47:0]           r_src_mac;
  logic [15:0]           r_eth_type;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_out_user;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_valid;
  logic                  r_skid_last;
  logic                  r_skid_user;

  logic                  w_in_payload;
  logic                  w_hdr_accept;
  logic                  w_pl_accept;
  logic                  w_hdr_done;
  logic                  w_hdr_valid_next;
  logic                  w_out_free;
  logic                  w_skid_valid_next;

  assign w_in_payload     = (r_state == ST_READ_PAYLOAD);
  assign w_hdr_accept     = s_axis_tvalid && r_s_ready && !w_in_payload;
  assign w_pl_accept      = s_axis_tvalid && r_s_ready &&  w_in_payload;
  assign w_hdr_done       = w_hdr_accept && !s_axis_tlast && (r_hdr_cnt == c_HDR_LAST_IDX);
  // A header stays pending until the downstream side takes it.
  assign w_hdr_valid_next = w_hdr_done || (r_hdr_valid && !m_eth_hdr_ready);
  // The output register can take new data when empty or being drained.
  assign w_out_free       = !r_out_valid || m_eth_payload_axis_tready;
  // Ready is low whenever the skid is full, so an accept implies an empty skid;
  // the skid only fills when a byte arrives while the output stage is stalled.
  assign w_skid_valid_next = !w_out_free && (r_skid_valid || w_pl_accept);

  // Next-state decode for the frame parser.
  always_comb begin
    w_state_next = r_state;
    if (w_in_payload) begin
      if (w_pl_accept && s_axis_tlast) begin
        w_state_next = ST_IDLE;
      end
    end else if (w_hdr_accept) begin
      if (s_axis_tlast) begin
        w_state_next = ST_IDLE;
      end else if (r_hdr_cnt == c_HDR_LAST_IDX) begin
        w_state_next = ST_READ_PAYLOAD;
      end else begin
        w_state_next = ST_READ_HEADER;
      end
    end
  end

  // Parser FSM: header capture, header handshake, early-termination flag, input ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hdr_cnt   <= 4'd0;
      r_s_ready   <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_dest_mac  <= 48'd0;
      r_src_mac   <= 48'd0;
      r_eth_type  <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hdr_valid <= w_hdr_valid_next;
      r_err       <= w_hdr_accept && s_axis_tlast;
      // Header bytes wait on the previous header; payload bytes wait on the skid.
      if (w_state_next == ST_READ_PAYLOAD) begin
        r_s_ready <= !w_skid_valid_next;
      end else begin
        r_s_ready <= !w_hdr_valid_next;
      end
      if (w_hdr_accept) begin
        if (s_axis_tlast || (r_hdr_cnt == c_HDR_LAST_IDX)) begin
          r_hdr_cnt <= 4'd0;
        end else begin
          r_hdr_cnt <= r_hdr_cnt + 4'd1;
        end
        // Shifting in from the LSB leaves the first byte of each field in its MSB.
        if (r_hdr_cnt < 4'd6) begin
          r_dest_mac <= {r_dest_mac[39:0], s_axis_tdata};
        end else if (r_hdr_cnt < 4'd12) begin
          r_src_mac  <= {r_src_mac[39:0], s_axis_tdata};
        end else begin
          r_eth_type <= {r_eth_type[7:0], s_axis_tdata};
        end
      end
    end
  end

  // Payload pipeline: output register refilled from the skid first, then from the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_user   <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_user  <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_data  <= r_skid_data;
          r_out_valid <= 1'b1;
          r_out_last  <= r_skid_last;
          r_out_user  <= r_skid_user;
        end else begin
          r_out_data  <= s_axis_tdata;
          r_out_valid <= w_pl_accept;
          r_out_last  <= w_pl_accept && s_axis_tlast;
          r_out_user  <= w_pl_accept && s_axis_tuser;
        end
        r_skid_valid <= 1'b0;
      end else if (w_pl_accept) begin
        r_skid_data  <= s_axis_tdata;
        r_skid_valid <= 1'b1;
        r_skid_last  <= s_axis_tlast;
        r_skid_user  <= s_axis_tuser;
      end
    end
  end

  assign s_axis_tready                  = r_s_ready;
  assign m_eth_hdr_valid                = r_hdr_valid;
  assign m_eth_dest_mac                 = r_dest_mac;
  assign m_eth_src_mac                  = r_src_mac;
  assign m_eth_type                     = r_eth_type;
  assign m_eth_payload_axis_tdata       = r_out_data;
  assign m_eth_payload_axis_tvalid      = r_out_valid;
  assign m_eth_payload_axis_tlast       = r_out_last;
  assign m_eth_payload_axis_tuser       = r_out_user;
  assign busy                           = (r_state != ST_IDLE);
  assign error_header_early_termination = r_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_rx_parse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_axis_rx_parse
//  Description : Directed self-checking bench for eth_axis_rx_parse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_axis_rx_parse;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        m_eth_hdr_valid;
  logic        m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  m_eth_payload_axis_tdata;
  logic        m_eth_payload_axis_tvalid;
  logic        m_eth_payload_axis_tready;
  logic        m_eth_payload_axis_tlast;
  logic        m_eth_payload_axis_tuser;
  logic        busy;
  logic        error_header_early_termination;

  always #5 clk = ~clk;

  eth_axis_rx_parse #(.DATA_WIDTH(8)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .s_axis_tdata                   (s_axis_tdata),
    .s_axis_tvalid                  (s_axis_tvalid),
    .s_axis_tready                  (s_axis_tready),
    .s_axis_tlast                   (s_axis_tlast),
    .s_axis_tuser                   (s_axis_tuser),
    .m_eth_hdr_valid                (m_eth_hdr_valid),
    .m_eth_hdr_ready                (m_eth_hdr_ready),
    .m_eth_dest_mac                 (m_eth_dest_mac),
    .m_eth_src_mac                  (m_eth_src_mac),
    .m_eth_type                     (m_eth_type),
    .m_eth_payload_axis_tdata       (m_eth_payload_axis_tdata),
    .m_eth_payload_axis_tvalid      (m_eth_payload_axis_tvalid),
    .m_eth_payload_axis_tready      (m_eth_payload_axis_tready),
    .m_eth_payload_axis_tlast       (m_eth_payload_axis_tlast),
    .m_eth_payload_axis_tuser       (m_eth_payload_axis_tuser),
    .busy                           (busy),
    .error_header_early_termination (error_header_early_termination)
  );

  // Headers as {dest, src, type}, transmitted MSB byte first.
  localparam logic [111:0] H1 = {48'h020000000001, 48'h5A5152535455, 16'h8000};
  localparam logic [111:0] H2 = {48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h0800};
  localparam logic [111:0] HA = {48'h111213141516, 48'h212223242526, 16'h0800};
  localparam logic [111:0] HB = {48'h313233343536, 48'h414243444546, 16'h86DD};
  localparam logic [111:0] HC = {48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h88B5};
  localparam logic [111:0] HD = {48'hD0D1D2D3D4D5, 48'hC0C1C2C3C4C5, 16'h0806};
  localparam logic [111:0] HE = {48'hE0E1E2E3E4E5, 48'hF0F1F2F3F4F5, 16'h9000};
  localparam logic [111:0] H6 = {48'h010203040506, 48'h0708090A0B0C, 16'h0D0E};

  logic [9:0]   pl_q[$];
  logic [111:0] hdr_q[$];
  int           hv_cycles  = 0;
  int           err_cycles = 0;
  int           err_pulses = 0;
  logic         err_d      = 1'b0;
  int           n_vec      = 0;
  int           n_err      = 0;
  bit           tx_done;

  // Record every completed output handshake and the error/valid activity.
  always @(negedge clk) begin
    if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready)
      pl_q.push_back({m_eth_payload_axis_tdata, m_eth_payload_axis_tlast, m_eth_payload_axis_tuser});
    if (m_eth_hdr_valid && m_eth_hdr_ready)
      hdr_q.push_back({m_eth_dest_mac, m_eth_src_mac, m_eth_type});
    if (m_eth_hdr_valid) hv_cycles++;
    if (error_header_early_termination) err_cycles++;
    if (error_header_early_termination && !err_d) err_pulses++;
    err_d = error_header_early_termination;
  end

  task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout: observed tready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_hdr(input logic [111:0] h, input int nbytes, input bit last_on_final);
    logic [111:0] hv;
    hv = h;
    for (int i = 0; i < nbytes; i++)
      send_byte(hv[111-8*i -: 8], last_on_final && (i == nbytes - 1), 1'b0);
  endtask

  task automatic send_pl(input int n, input logic [7:0] base, input logic [7:0] step, input bit user_last);
    for (int i = 0; i < n; i++)
      send_byte(base + 8'(i * step), i == n - 1, user_last && (i == n - 1));
  endtask

  task automatic chk_pl(input string tag, input int start, input int n, input logic [7:0] base,
                        input logic [7:0] step, input bit user_last);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i * step);
      chk($sformatf("%s[%0d]", tag, i), pl_q[start + i],
          {d, i == n - 1, user_last && (i == n - 1)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_hdr_valid"}, m_eth_hdr_valid, 0);
    chk({tag, "_pl_valid"}, m_eth_payload_axis_tvalid, 0);
    chk({tag, "_pl_last_user"}, {m_eth_payload_axis_tlast, m_eth_payload_axis_tuser}, 0);
    chk({tag, "_busy_err"}, {busy, error_header_early_termination}, 0);
    chk({tag, "_fields"}, {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, 0);
  endtask

  initial begin
    int  pb, hb, hvb, ecb, epb;
    bit  saw_ready;

    rst = 1'b0;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_eth_hdr_ready = 1'b1;
    m_eth_payload_axis_tready = 1'b1;
    tx_done = 1'b0;

    // Reset state and ready rising on the first edge after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("rst0");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", s_axis_tready, 1);

    // Basic frame with all readies high
    pb = pl_q.size(); hb = hdr_q.size(); hvb = hv_cycles;
    send_hdr(H1, 14, 0);
    send_pl(10, 8'h00, 8'h01, 0);
    idle(4);
    chk("f1_hdr_count", hdr_q.size() - hb, 1);
    chk("f1_hdr_fields", hdr_q[hb], H1);
    chk("f1_hv_cycles", hv_cycles - hvb, 1);
    chk("f1_pl_count", pl_q.size() - pb, 10);
    chk_pl("f1_pl", pb, 10, 8'h00, 8'h01, 0);
    chk("f1_busy", busy, 0);

    // Short frame ending inside the header
    pb = pl_q.size(); hb = hdr_q.size(); hvb = hv_cycles; ecb = err_cycles; epb = err_pulses;
    send_hdr(H2, 10, 1);
    idle(3);
    chk("short_err_pulses", err_pulses - epb, 1);
    chk("short_err_cycles", err_cycles - ecb, 1);
    chk("short_no_hdr", hv_cycles - hvb, 0);
    chk("short_no_pl", pl_q.size() - pb, 0);
    chk("short_busy", busy, 0);

    // Back-to-back frames with the header handshake stalled
    pb = pl_q.size(); hb = hdr_q.size();
    m_eth_hdr_ready = 1'b0;
    send_hdr(HA, 14, 0);
    send_pl(4, 8'h40, 8'h01, 0);
    s_axis_tdata = HB[111:104]; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tvalid = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axis_tready) saw_ready = 1'b1;
    end
    chk("b2b_b0_blocked", saw_ready, 0);
    chk("b2b_a_pl_done", pl_q.size() - pb, 4);
    chk("b2b_a_hdr_held", {m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type}, {1'b1, HA});
    @(posedge clk); #1;
    m_eth_hdr_ready = 1'b1;
    send_hdr(HB, 14, 0);
    send_pl(3, 8'h80, 8'h01, 0);
    idle(4);
    chk("b2b_hdr_count", hdr_q.size() - hb, 2);
    chk("b2b_hdr_a", hdr_q[hb], HA);
    chk("b2b_hdr_b", hdr_q[hb + 1], HB);
    chk("b2b_pl_count", pl_q.size() - pb, 7);
    chk_pl("b2b_a_pl", pb, 4, 8'h40, 8'h01, 0);
    chk_pl("b2b_b_pl", pb + 4, 3, 8'h80, 8'h01, 0);

    // 64-byte payload under a random output ready
    pb = pl_q.size(); hb = hdr_q.size();
    tx_done = 1'b0;
    fork
      begin
        send_hdr(HC, 14, 0);
        send_pl(64, 8'h03, 8'h07, 1);
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk); #1;
          m_eth_payload_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_eth_payload_axis_tready = 1'b1;
    idle(5);
    chk("rnd_hdr", hdr_q[hb], HC);
    chk("rnd_pl_count", pl_q.size() - pb, 64);
    chk_pl("rnd_pl", pb, 64, 8'h03, 8'h07, 1);

    // Reset in the middle of a header
    pb = pl_q.size(); hb = hdr_q.size();
    send_hdr(HD, 8, 0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("mid_rst2");
    rst = 1'b1;
    @(posedge clk); #1;
    send_hdr(HE, 14, 0);
    send_pl(5, 8'hC8, 8'h03, 0);
    idle(4);
    chk("post_rst_hdr_count", hdr_q.size() - hb, 1);
    chk("post_rst_hdr", hdr_q[hb], HE);
    chk("post_rst_pl_count", pl_q.size() - pb, 5);
    chk_pl("post_rst_pl", pb, 5, 8'hC8, 8'h03, 0);

    // Frame ending exactly on the last header byte
    pb = pl_q.size(); hvb = hv_cycles; ecb = err_cycles; epb = err_pulses;
    send_hdr(H6, 14, 1);
    idle(3);
    chk("h14_err_pulses", err_pulses - epb, 1);
    chk("h14_err_cycles", err_cycles - ecb, 1);
    chk("h14_no_hdr", hv_cycles - hvb, 0);
    chk("h14_no_pl", pl_q.size() - pb, 0);
    chk("h14_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
